// File: rtl/xy_scan_arbiter.sv
// Round-robin vector beam arbiter: grants one of four XY sources per slot and drives X/Y/Z.
// Optional blanked settle after each source switch is built when XY_SETTLE_BLANK_EN is defined.
module xy_scan_arbiter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  input  logic [31:0] x_src,
  input  logic [31:0] y_src,
  input  logic [7:0]  dwell,
  output logic [7:0]  x,
  output logic [7:0]  y,
  output logic        beam_on,
  output logic [1:0]  cur_src,
  output logic [3:0]  ack
);

`ifdef XY_SETTLE_BLANK_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SETTLE = 2'd1, DWELL = 2'd2} state_t;
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
`else
  typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd2} state_t;
`endif

  state_t      state, state_nxt;
  logic [1:0]  last, last_nxt;
  logic [7:0]  dwell_len, dwell_len_nxt;
  logic [7:0]  dwell_cnt, dwell_cnt_nxt;
  logic [7:0]  x_nxt, y_nxt;
  logic [1:0]  cur_src_nxt;
  logic        beam_nxt;
  logic [3:0]  ack_nxt;
  logic [1:0]  base, winner, idx;
  logic        found, grant, dwell_last;
`ifdef XY_SETTLE_BLANK_EN
  logic [3:0]  settle_cnt, settle_cnt_nxt;
`endif

  // Back-to-back grants search from the source currently finishing, not the stale last.
  always_comb begin
    base   = (state == DWELL) ? cur_src : last;
    winner = base;
    found  = 1'b0;
    idx    = base;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  assign dwell_last = (dwell_cnt == dwell_len - 8'd1);

  always_comb begin
    state_nxt     = state;
    last_nxt      = last;
    dwell_len_nxt = dwell_len;
    dwell_cnt_nxt = dwell_cnt;
    x_nxt         = x;
    y_nxt         = y;
    cur_src_nxt   = cur_src;
    beam_nxt      = beam_on;
    ack_nxt       = 4'b0000;
    grant         = 1'b0;
`ifdef XY_SETTLE_BLANK_EN
    settle_cnt_nxt = settle_cnt;
`endif
    case (state)
      IDLE: begin
        beam_nxt = 1'b0;
        if (found) grant = 1'b1;
      end
`ifdef XY_SETTLE_BLANK_EN
      SETTLE: begin
        if (settle_cnt == SETTLE_LAST) begin
          state_nxt     = DWELL;
          beam_nxt      = 1'b1;
          dwell_cnt_nxt = 8'd0;
        end else begin
          settle_cnt_nxt = settle_cnt + 4'd1;
        end
      end
`endif
      DWELL: begin
        if (dwell_last) begin
          last_nxt         = cur_src;
          ack_nxt[cur_src] = req[cur_src];
          if (found) begin
            grant = 1'b1;
          end else begin
            state_nxt = IDLE;
            beam_nxt  = 1'b0;
          end
        end else begin
          dwell_cnt_nxt = dwell_cnt + 8'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        beam_nxt  = 1'b0;
      end
    endcase

    // Coordinates and dwell length are latched only here and held for the whole slot.
    if (grant) begin
      x_nxt         = x_src[{winner, 3'b000} +: 8];
      y_nxt         = y_src[{winner, 3'b000} +: 8];
      cur_src_nxt   = winner;
      dwell_len_nxt = (dwell == 8'd0) ? 8'd1 : dwell;
      dwell_cnt_nxt = 8'd0;
`ifdef XY_SETTLE_BLANK_EN
      state_nxt      = SETTLE;
      beam_nxt       = 1'b0;
      settle_cnt_nxt = 4'd0;
`else
      state_nxt = DWELL;
      beam_nxt  = 1'b1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      last      <= 2'd3;
      dwell_len <= 8'd1;
      dwell_cnt <= 8'd0;
      x         <= 8'h80;
      y         <= 8'h80;
      cur_src   <= 2'd0;
      beam_on   <= 1'b0;
      ack       <= 4'b0000;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      dwell_len <= dwell_len_nxt;
      dwell_cnt <= dwell_cnt_nxt;
      x         <= x_nxt;
      y         <= y_nxt;
      cur_src   <= cur_src_nxt;
      beam_on   <= beam_nxt;
      ack       <= ack_nxt;
    end
  end

`ifdef XY_SETTLE_BLANK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) settle_cnt <= 4'd0;
    else     settle_cnt <= settle_cnt_nxt;
  end
`endif

endmodule

// File: tb/tb_xy_scan_arbiter.sv
// Scoreboard bench for xy_scan_arbiter: stimulus queues expected ack pulses with their cycle,
// a monitor pops them as the DUT pulses ack; beam/coordinate checks are done inline.
module tb_xy_scan_arbiter;

`ifdef XY_SETTLE_BLANK_EN
  localparam int S = 2;
`else
  localparam int S = 0;
`endif

  logic        clk, rst;
  logic [3:0]  req;
  logic [31:0] x_src, y_src;
  logic [7:0]  dwell;
  logic [7:0]  x, y;
  logic        beam_on;
  logic [1:0]  cur_src;
  logic [3:0]  ack;

  xy_scan_arbiter #(.SETTLE_CYCLES(2)) dut (
    .clk(clk), .rst(rst), .req(req), .x_src(x_src), .y_src(y_src), .dwell(dwell),
    .x(x), .y(y), .beam_on(beam_on), .cur_src(cur_src), .ack(ack)
  );

  typedef struct {int cyc; logic [3:0] ack;} exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int c, p, j;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("[TB] FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [3:0] r, input logic [7:0] d);
    req   = r;
    dwell = d;
  endtask

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic push_ack(input int at, input logic [3:0] a);
    sb.push_back('{at, a});
  endtask

  function automatic logic beam_exp(input int k, input int per);
    return ((k - 1) % per) >= S;
  endfunction

  // Monitor: every ack pulse must match the head of the scoreboard in value and cycle.
  initial begin
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        total++;
        bad++;
        $display("[TB] FAIL ack_missed: got no ack at cycle %0d, required %b", sb[0].cyc, sb[0].ack);
        void'(sb.pop_front());
      end
      if (!rst && ack != 4'b0000) begin
        if (sb.size() == 0 || sb[0].cyc != cyc) begin
          total++;
          bad++;
          $display("[TB] FAIL ack_unexpected: got %b at cycle %0d, required 0000", ack, cyc);
        end else begin
          checkOutput("ack_value", {28'd0, ack}, {28'd0, sb[0].ack});
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    dwell = 8'd1;
    x_src = {8'h13, 8'h12, 8'h11, 8'h10};
    y_src = {8'h23, 8'h22, 8'h21, 8'h20};

    // Reset state
    tick; tick;
    checkOutput("rst_x", x, 8'h80);
    checkOutput("rst_y", y, 8'h80);
    checkOutput("rst_beam", beam_on, 0);
    checkOutput("rst_ack", ack, 0);
    checkOutput("rst_src", cur_src, 0);
    rst = 1'b0;
    tick;

    // Single source, mid-slot coordinate/dwell changes ignored
    applyStimulus(4'b0001, 8'd3);
    c = cyc; p = S + 3;
    push_ack(c + p + 1, 4'b0001);
    push_ack(c + 2*p + 1, 4'b0001);
    for (int k = 1; k <= 2*p + 1; k++) begin
      tick;
      checkOutput("t1_beam", beam_on, beam_exp(k, p));
      checkOutput("t1_x", x, 8'h10);
      checkOutput("t1_y", y, 8'h20);
      if (k == S + 1) begin x_src[7:0] = 8'h99; dwell = 8'd7; end
      if (k == p - 1) begin x_src[7:0] = 8'h10; dwell = 8'd3; end
      if (k == 2*p + 1) req = 4'b0000;
    end
    repeat (p + 1) tick;
    checkOutput("t1_idle_beam", beam_on, 0);
    checkOutput("t1_idle_x", x, 8'h10);

    // Round-robin from reset, all requesting
    rst = 1'b1; tick; rst = 1'b0;
    applyStimulus(4'b1111, 8'd1);
    c = cyc; p = S + 1;
    for (int jj = 0; jj < 5; jj++) push_ack(c + (jj + 1)*p + 1, 4'(1 << (jj % 4)));
    for (int k = 1; k <= 5*p + 1; k++) begin
      tick;
      j = (k - 1) / p;
      checkOutput("t2_src", cur_src, j % 4);
      checkOutput("t2_x", x, 16 + (j % 4));
      checkOutput("t2_beam", beam_on, beam_exp(k, p));
      if (k == 5*p + 1) req = 4'b0000;
    end
    repeat (p + 1) tick;
    checkOutput("t2_idle_beam", beam_on, 0);

    // Dwell of zero behaves as one
    applyStimulus(4'b0100, 8'd0);
    c = cyc; p = S + 1;
    push_ack(c + p + 1, 4'b0100);
    push_ack(c + 2*p + 1, 4'b0100);
    for (int k = 1; k <= 2*p + 1; k++) begin
      tick;
      checkOutput("t3_beam", beam_on, beam_exp(k, p));
      checkOutput("t3_src", cur_src, 2);
      checkOutput("t3_x", x, 8'h12);
      if (k == 2*p + 1) req = 4'b0000;
    end
    repeat (p + 1) tick;
    checkOutput("t3_idle_beam", beam_on, 0);

    // Source 1 drops mid-slot: slot completes, no ack, next grant searches 2,3,0
    applyStimulus(4'b0010, 8'd4);
    c = cyc; p = S + 4;
    push_ack(c + 2*p + 1, 4'b1000);
    for (int k = 1; k <= 2*p + 1; k++) begin
      tick;
      checkOutput("t4_beam", beam_on, beam_exp(k, p));
      checkOutput("t4_src", cur_src, (k <= p) ? 1 : ((k <= 2*p) ? 3 : 0));
      if (k == p + 1) checkOutput("t4_noack", ack, 0);
      if (k == S + 2) req = 4'b1001;
      if (k == 2*p + 1) req = 4'b0000;
    end
    repeat (p + 1) tick;
    checkOutput("t4_idle_beam", beam_on, 0);

    // Idle hold after a slot
    x_src[7:0] = 8'h55;
    applyStimulus(4'b0001, 8'd2);
    p = S + 2;
    tick;
    checkOutput("t5_src", cur_src, 0);
    checkOutput("t5_x", x, 8'h55);
    req = 4'b0000;
    repeat (p) tick;
    x_src[7:0] = 8'hAA;
    for (int k = 0; k < 20; k++) begin
      tick;
      checkOutput("t5_hold_beam", beam_on, 0);
      checkOutput("t5_hold_x", x, 8'h55);
    end
    x_src[7:0] = 8'h10;

    // Reset mid-dwell abandons the slot; first grant on first edge after release
    applyStimulus(4'b0001, 8'd8);
    p = S + 8;
    repeat (S + 3) tick;
    checkOutput("t6_pre_beam", beam_on, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_x", x, 8'h80);
    checkOutput("t6_rst_y", y, 8'h80);
    checkOutput("t6_rst_beam", beam_on, 0);
    checkOutput("t6_rst_ack", ack, 0);
    checkOutput("t6_rst_src", cur_src, 0);
    tick; tick;
    rst = 1'b0;
    tick;
    checkOutput("t6_first_x", x, 8'h10);
    checkOutput("t6_first_beam", beam_on, (S == 0) ? 1 : 0);
    req = 4'b0000;
    repeat (p + 2) tick;
    checkOutput("t6_idle_beam", beam_on, 0);

    repeat (3) tick;
    checkOutput("sb_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xy_scan_arbiter.md
XY_SCAN_ARBITER -- requirements
Module: xy_scan_arbiter

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of blanked settle cycles after a source switch; legal range 1..15.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  per-source draw request: bit0 ball, bit1 left paddle, bit2 right paddle, bit3 border.
REQ-005 x_src  input  32  packed source X coordinates; source n occupies bits [8n+7:8n].
REQ-006 y_src  input  32  packed source Y coordinates, same packing as x_src.
REQ-007 dwell  input  8  beam-on cycles per slot; 0 SHALL be treated as 1.
REQ-008 x  output  8  registered X DAC code.
REQ-009 y  output  8  registered Y DAC code.
REQ-010 beam_on  output  1  registered Z/unblank; 1 only while a slot is dwelling.
REQ-011 cur_src  output  2  registered index of the most recently granted source.
REQ-012 ack  output  4  one-cycle per-source completion pulse.

Function
REQ-013 FSM states: IDLE, SETTLE, DWELL; exactly one active.
REQ-014 Arbitration: round-robin; the search starts at (last+1) mod 4; the winner is the first source with req set.
REQ-015 Grant edge, from IDLE or from the last DWELL cycle with req != 0: x <= x_src[winner], y <= y_src[winner], cur_src <= winner; dwell sampled as D = max(dwell,1).
REQ-016 Coordinates and dwell are captured only on the grant edge; changes mid-slot SHALL be ignored.
REQ-017 From the grant edge, with settle enabled: enter SETTLE with beam_on = 0 for exactly SETTLE_CYCLES cycles, then DWELL.
REQ-018 From the grant edge, with settle disabled: enter DWELL directly.
REQ-019 In DWELL, beam_on SHALL be 1 for exactly D consecutive cycles.
REQ-020 On the last DWELL cycle edge: last <= cur_src; ack[cur_src] <= 1 for one cycle, only if req[cur_src] is still 1; all other ack bits remain 0.
REQ-021 On the last DWELL cycle edge with req != 0: grant back-to-back per REQ-015, with no IDLE cycle.
REQ-022 On the last DWELL cycle edge with req == 0: go to IDLE, beam_on <= 0, x/y/cur_src hold.
REQ-023 In IDLE with req == 0: beam_on = 0 and all outputs hold.
REQ-024 A requester dropping req mid-slot SHALL NOT abort the slot; the slot completes with no ack.
REQ-025 A request rising during SETTLE or DWELL SHALL wait for the next grant edge.
REQ-026 Starvation bound: with all four requests held high, each source SHALL be granted once in every four slots.

Reset
REQ-027 rst asserted: immediately state = IDLE, x = 8'h80, y = 8'h80, beam_on = 0, ack = 0, cur_src = 0, last = 3, counters = 0.
REQ-028 rst asserted mid-SETTLE or mid-DWELL: the slot SHALL be abandoned with no ack.
REQ-029 First grant after rst deasserts: evaluated on the first rising edge of clk.

Configuration
REQ-030 Macro XY_SETTLE_BLANK_EN defined: SETTLE state and SETTLE_CYCLES are active per REQ-017; slot period is SETTLE_CYCLES + D cycles.
REQ-031 Macro XY_SETTLE_BLANK_EN undefined: the SETTLE state is not built and SETTLE_CYCLES is ignored; DWELL follows grant directly (REQ-018); slot period is D cycles.

Verification
REQ-032 Reset: assert rst mid-DWELL -> x = y = 8'h80, beam_on = 0, ack = 0 in the same cycle; no ack after release.
REQ-033 Single source: req = 4'b0001, x_src[7:0] = 8'h10, y_src[7:0] = 8'h20, dwell = 3, macro on, SETTLE_CYCLES = 2 -> x = 8'h10, y = 8'h20; beam_on 0,0,1,1,1 repeating; ack[0] pulses every 5 cycles.
REQ-034 Round-robin: req = 4'b1111, dwell = 1, macro off -> cur_src sequence 0,1,2,3,0; beam_on constant 1; ack one-hot rotating.
REQ-035 Dwell zero: dwell = 0, req = 4'b0100 -> identical timing to dwell = 1; ack[2] pulses.
REQ-036 Drop mid-slot: req[1] deasserted during DWELL, dwell = 4 -> beam_on still high 4 cycles; ack[1] stays 0; next grant goes to the lowest-index pending source after 1 (search order 2, 3, 0).
REQ-037 Idle hold: req -> 0 after a slot with x = 8'h55 -> beam_on = 0; x holds 8'h55 indefinitely.
